// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared definitions for the packet mux: grant policy codes
//                and the packet-lock state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    // Grant policy selector values for pkt_mux_reg.MODE
    localparam int MODE_SEL = 0;   // explicit channel select via sel/sel_en
    localparam int MODE_RR  = 1;   // round-robin among valid channels

    // IDLE: no channel owns the output; LOCK: a packet is in progress
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

endpackage : mux_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin search. Returns the first
//                requesting index at or above ptr, wrapping N-1 -> 0.
//  Ports       : req[N]      - request vector
//                ptr[SW]     - search start index (0..N-1)
//                grant[SW]   - chosen index (0 when nothing requested)
//                grant_valid - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 2,
    parameter int SW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] grant,
    output logic          grant_valid
);

    localparam int          NP  = 2 ** SW;
    localparam logic [SW:0] c_N = (SW + 1)'(N);

    // Requests padded to a power of two so any SW-bit index is in range
    logic [NP-1:0] w_req_pad;
    logic [SW:0]   w_idx;

    // Walk the offsets from farthest to nearest so the nearest requester
    // (the one closest to ptr going upward) is the last to write grant.
    always_comb begin
        w_req_pad         = '0;
        w_req_pad[N-1:0]  = req;
        grant             = '0;
        grant_valid       = 1'b0;
        w_idx             = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = {1'b0, ptr} + (SW + 1)'(k);
            if (w_idx >= c_N) begin
                w_idx = w_idx - c_N;
            end
            if (w_req_pad[w_idx[SW-1:0]]) begin
                grant       = w_idx[SW-1:0];
                grant_valid = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/pkt_mux_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_mux_reg
//  Description : N-to-1 packet multiplexer with a single registered output
//                stage. A channel is granted at packet start and held until
//                its last beat transfers. Grant is chosen by explicit select
//                (MODE_SEL) or round-robin (MODE_RR).
//  Ports       : clk, areset_n              - clock, async active-low reset
//                in_valid/in_data/in_last   - N input channels
//                in_ready                   - per-channel accept (one-hot/0)
//                sel_en, sel                - channel select (MODE_SEL only)
//                out_valid/out_data/out_last- registered output beat
//                out_ready                  - downstream accept
//  Revision    : 1.0 - initial release
// ============================================================================
module pkt_mux_reg
    import mux_pkg::*;
#(
    parameter  int W    = 8,
    parameter  int N    = 2,
    parameter  int MODE = MODE_SEL,
    localparam int SW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           areset_n,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    input  logic           sel_en,
    input  logic [SW-1:0]  sel,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    input  logic           out_ready
);

    localparam logic [SW:0] c_N = (SW + 1)'(N);

    // ------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------
    if (N < 2 || N > 16) begin : g_chk_n
        $error("pkt_mux_reg: N must be in 2..16");
    end
    if (MODE != MODE_SEL && MODE != MODE_RR) begin : g_chk_mode
        $error("pkt_mux_reg: MODE must be MODE_SEL or MODE_RR");
    end
    if (W < 1) begin : g_chk_w
        $error("pkt_mux_reg: W must be >= 1");
    end

    state_t        r_state, w_state_nxt;
    logic [SW-1:0] r_grant, w_grant_nxt;
    logic [SW-1:0] r_rr_ptr, w_rr_ptr_nxt;

    logic          r_out_valid;
    logic [W-1:0]  r_out_data;
    logic          r_out_last;

    logic [SW-1:0] w_cand;       // IDLE candidate channel
    logic          w_cand_ok;    // candidate exists and is in range
    logic          w_locked;
    logic          w_load_ok;    // output register can take a beat
    logic [SW-1:0] w_gidx;       // channel currently granted
    logic          w_g_ok;
    logic [N-1:0]  w_ready;
    logic          w_xfer;
    logic [W-1:0]  w_xdata;
    logic          w_xlast;

    // ------------------------------------------------------------------
    // Candidate selection while IDLE
    // ------------------------------------------------------------------
    if (MODE == MODE_RR) begin : g_rr
        rr_arbiter #(
            .N  (N),
            .SW (SW)
        ) u_rr_arbiter (
            .req         (in_valid),
            .ptr         (r_rr_ptr),
            .grant       (w_cand),
            .grant_valid (w_cand_ok)
        );
    end else begin : g_sel
        // Out-of-range select (sel >= N) grants nobody
        always_comb begin
            w_cand    = sel_en ? sel : '0;
            w_cand_ok = ({1'b0, w_cand} < c_N);
        end
    end

    assign w_locked  = (r_state == LOCK);
    assign w_load_ok = !r_out_valid || out_ready;
    assign w_gidx    = w_locked ? r_grant : w_cand;
    assign w_g_ok    = w_locked || w_cand_ok;

    // While locked the owner is ready even without valid; while idle only a
    // valid candidate is, so an idle channel's ready never appears alone.
    // Ready is forced low for the whole time reset is asserted.
    for (genvar g = 0; g < N; g++) begin : g_ready
        assign w_ready[g] = areset_n && w_load_ok && w_g_ok &&
                            (w_gidx == SW'(g)) && (w_locked || in_valid[g]);
    end

    assign in_ready = w_ready;
    assign w_xfer   = |(w_ready & in_valid);

    // Beat mux: at most one ready bit is set, so a priority loop is safe
    always_comb begin
        w_xdata = '0;
        w_xlast = 1'b0;
        for (int g = 0; g < N; g++) begin
            if (w_ready[g] && in_valid[g]) begin
                w_xdata = in_data[g*W +: W];
                w_xlast = in_last[g];
            end
        end
    end

    // ------------------------------------------------------------------
    // Packet lock FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        if (w_xfer) begin
            case (r_state)
                IDLE: begin
                    // Single-beat packets never take the lock
                    if (!w_xlast) begin
                        w_state_nxt = LOCK;
                        w_grant_nxt = w_gidx;
                    end
                end
                LOCK: begin
                    if (w_xlast) begin
                        w_state_nxt = IDLE;
                    end
                end
            endcase
            // Next round-robin search starts just past the finishing owner
            if (w_xlast) begin
                w_rr_ptr_nxt = ({1'b0, w_gidx} == c_N - 1'b1) ? '0 : w_gidx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register: data/last only change when a new beat is loaded,
    // so they hold stable under backpressure.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (w_load_ok) begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
                r_out_data <= w_xdata;
                r_out_last <= w_xlast;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule : pkt_mux_reg
`default_nettype wire

// File: tb/tb_pkt_mux_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pkt_mux_reg
//  Description : Self-checking bench for pkt_mux_reg. Three instances:
//                A = MODE_SEL N=2, B = MODE_SEL N=3, C = MODE_RR N=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pkt_mux_reg;

    logic clk = 1'b0;
    logic areset_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A: MODE_SEL, N=2 ----------------
    logic [1:0]  a_in_valid, a_in_last, a_in_ready;
    logic [15:0] a_in_data;
    logic        a_sel_en, a_out_valid, a_out_last, a_out_ready;
    logic [0:0]  a_sel;
    logic [7:0]  a_out_data;

    pkt_mux_reg #(.W(8), .N(2), .MODE(mux_pkg::MODE_SEL)) dut_a (
        .clk(clk), .areset_n(areset_n),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_last(a_in_last),
        .in_ready(a_in_ready), .sel_en(a_sel_en), .sel(a_sel),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_last(a_out_last),
        .out_ready(a_out_ready)
    );

    // ---------------- instance B: MODE_SEL, N=3 ----------------
    logic [2:0]  b_in_valid, b_in_last, b_in_ready;
    logic [23:0] b_in_data;
    logic        b_sel_en, b_out_valid, b_out_last, b_out_ready;
    logic [1:0]  b_sel;
    logic [7:0]  b_out_data;

    pkt_mux_reg #(.W(8), .N(3), .MODE(mux_pkg::MODE_SEL)) dut_b (
        .clk(clk), .areset_n(areset_n),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_last(b_in_last),
        .in_ready(b_in_ready), .sel_en(b_sel_en), .sel(b_sel),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last),
        .out_ready(b_out_ready)
    );

    // ---------------- instance C: MODE_RR, N=4 ----------------
    logic [3:0]  c_in_valid, c_in_last, c_in_ready;
    logic [31:0] c_in_data;
    logic        c_sel_en, c_out_valid, c_out_last, c_out_ready;
    logic [1:0]  c_sel;
    logic [7:0]  c_out_data;

    pkt_mux_reg #(.W(8), .N(4), .MODE(mux_pkg::MODE_RR)) dut_c (
        .clk(clk), .areset_n(areset_n),
        .in_valid(c_in_valid), .in_data(c_in_data), .in_last(c_in_last),
        .in_ready(c_in_ready), .sel_en(c_sel_en), .sel(c_sel),
        .out_valid(c_out_valid), .out_data(c_out_data), .out_last(c_out_last),
        .out_ready(c_out_ready)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t qa[$];
    beat_t qc[$];

    typedef struct {
        logic [1:0] v;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] l;
        logic       se;
        logic       s;
        logic       ordy;
        logic [1:0] er;     // expected in_ready
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_cmp(input string name, inout beat_t q[$],
                           input logic [7:0] d, input logic l);
        beat_t b;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: output beat 0x%0h with no expected beat queued", name, d);
        end else begin
            b = q.pop_front();
            chk({name, "_data"}, {24'h0, d}, {24'h0, b.d});
            chk({name, "_last"}, {31'h0, l}, {31'h0, b.l});
        end
    endtask

    initial begin
        beat_t bt;
        logic  exp_ov;
        logic  xfer;
        int    eg[7];

        // Row fields: v, d0, d1, l, sel_en, sel, out_ready, expected in_ready
        tbl[0]  = '{2'b11, 8'hA5, 8'hC3, 2'b11, 1'b0, 1'b0, 1'b1, 2'b01};
        tbl[1]  = '{2'b10, 8'h00, 8'hC3, 2'b10, 1'b0, 1'b0, 1'b1, 2'b00};
        tbl[2]  = '{2'b10, 8'h00, 8'h11, 2'b00, 1'b1, 1'b1, 1'b1, 2'b10};
        tbl[3]  = '{2'b11, 8'h77, 8'h22, 2'b00, 1'b1, 1'b0, 1'b1, 2'b10};
        tbl[4]  = '{2'b11, 8'h77, 8'h33, 2'b10, 1'b1, 1'b0, 1'b1, 2'b10};
        tbl[5]  = '{2'b01, 8'h77, 8'h00, 2'b01, 1'b1, 1'b0, 1'b1, 2'b01};
        tbl[6]  = '{2'b01, 8'h5A, 8'h00, 2'b01, 1'b0, 1'b0, 1'b1, 2'b01};
        tbl[7]  = '{2'b01, 8'h66, 8'h00, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00};
        tbl[8]  = '{2'b01, 8'h66, 8'h00, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00};
        tbl[9]  = '{2'b01, 8'h66, 8'h00, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00};
        tbl[10] = '{2'b01, 8'h66, 8'h00, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00};
        tbl[11] = '{2'b01, 8'h66, 8'h00, 2'b01, 1'b0, 1'b0, 1'b1, 2'b01};
        tbl[12] = '{2'b01, 8'h67, 8'h00, 2'b01, 1'b0, 1'b0, 1'b1, 2'b01};
        tbl[13] = '{2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00};
        tbl[14] = '{2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00};

        eg = '{0, 1, 2, 3, 0, 2, 0};

        // ---------------- reset state (valids high to prove gating) ----
        areset_n   = 1'b0;
        a_in_valid = 2'b11; a_in_data = 16'h1234; a_in_last = 2'b11;
        a_sel_en   = 1'b0;  a_sel = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 3'b000; b_in_data = 24'h0; b_in_last = 3'b000;
        b_sel_en   = 1'b0;  b_sel = 2'd0; b_out_ready = 1'b1;
        c_in_valid = 4'hF;  c_in_data = 32'h0; c_in_last = 4'hF;
        c_sel_en   = 1'b0;  c_sel = 2'd0; c_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_out_valid", {31'h0, a_out_valid}, 32'h0);
        chk("rst_a_out_data",  {24'h0, a_out_data},  32'h0);
        chk("rst_a_out_last",  {31'h0, a_out_last},  32'h0);
        chk("rst_a_in_ready",  {30'h0, a_in_ready},  32'h0);
        chk("rst_c_in_ready",  {28'h0, c_in_ready},  32'h0);
        a_in_valid = 2'b00;
        c_in_valid = 4'h0;
        @(negedge clk);
        areset_n = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- table: instance A ----------------
        exp_ov = 1'b0;
        for (int i = 0; i < 15; i++) begin
            a_in_valid  = tbl[i].v;
            a_in_data   = {tbl[i].d1, tbl[i].d0};
            a_in_last   = tbl[i].l;
            a_sel_en    = tbl[i].se;
            a_sel       = tbl[i].s;
            a_out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("a_out_valid[%0d]", i), {31'h0, a_out_valid}, {31'h0, exp_ov});
            if (a_out_valid && a_out_ready) begin
                pop_cmp($sformatf("a_out[%0d]", i), qa, a_out_data, a_out_last);
            end else if (a_out_valid && qa.size() > 0) begin
                chk($sformatf("a_hold[%0d]", i), {24'h0, a_out_data}, {24'h0, qa[0].d});
            end
            chk($sformatf("a_in_ready[%0d]", i), {30'h0, a_in_ready}, {30'h0, tbl[i].er});
            xfer = |(tbl[i].er & tbl[i].v);
            if (xfer) begin
                bt.d = tbl[i].er[1] ? tbl[i].d1 : tbl[i].d0;
                bt.l = tbl[i].er[1] ? tbl[i].l[1] : tbl[i].l[0];
                qa.push_back(bt);
            end
            exp_ov = xfer | (exp_ov & ~tbl[i].ordy);
            @(posedge clk);
            #1;
        end
        chk("a_sb_drained", qa.size(), 32'd0);

        // ---------------- instance B: out-of-range select ----------------
        b_in_valid = 3'b111; b_in_data = {8'hB2, 8'hB1, 8'hB0}; b_in_last = 3'b111;
        b_sel_en = 1'b1; b_sel = 2'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("b_sel3_ready[%0d]", i), {29'h0, b_in_ready}, 32'h0);
            chk($sformatf("b_sel3_ovalid[%0d]", i), {31'h0, b_out_valid}, 32'h0);
            @(posedge clk);
            #1;
        end
        b_sel = 2'd2;
        @(negedge clk);
        chk("b_sel2_ready", {29'h0, b_in_ready}, 32'h4);
        @(posedge clk);
        #1;
        b_sel_en = 1'b0; b_sel = 2'd3;
        @(negedge clk);
        chk("b_sel2_ovalid", {31'h0, b_out_valid}, 32'h1);
        chk("b_sel2_data", {24'h0, b_out_data}, 32'hB2);
        chk("b_default_ready", {29'h0, b_in_ready}, 32'h1);
        @(posedge clk);
        #1;
        b_in_valid = 3'b000;
        @(negedge clk);
        chk("b_default_data", {24'h0, b_out_data}, 32'hB0);
        @(posedge clk);
        #1;

        // ---------------- instance C: round-robin order ----------------
        c_in_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        c_in_last = 4'hF;
        for (int k = 0; k < 7; k++) begin
            c_in_valid = (k < 5) ? 4'hF : 4'h5;
            @(negedge clk);
            chk($sformatf("c_ovalid[%0d]", k), {31'h0, c_out_valid},
                (qc.size() > 0) ? 32'h1 : 32'h0);
            if (c_out_valid) begin
                pop_cmp($sformatf("c_out[%0d]", k), qc, c_out_data, c_out_last);
            end
            chk($sformatf("c_grant[%0d]", k), {28'h0, c_in_ready}, 32'h1 << eg[k]);
            bt.d = 8'hC0 + 8'(eg[k]);
            bt.l = 1'b1;
            qc.push_back(bt);
            @(posedge clk);
            #1;
        end
        c_in_valid = 4'h0;
        @(negedge clk);
        chk("c_ovalid_tail", {31'h0, c_out_valid}, 32'h1);
        if (c_out_valid) begin
            pop_cmp("c_out_tail", qc, c_out_data, c_out_last);
        end
        @(posedge clk);
        #1;

        // ---------------- reset mid-packet on instance A ----------------
        a_in_valid = 2'b10; a_in_data = {8'h11, 8'h00}; a_in_last = 2'b00;
        a_sel_en = 1'b1; a_sel = 1'b1; a_out_ready = 1'b1;
        @(negedge clk);
        chk("rst_pkt_ready", {30'h0, a_in_ready}, 32'h2);
        @(posedge clk);
        #1;
        a_in_data = {8'h22, 8'h00};
        #1;
        areset_n = 1'b0;
        #1;
        chk("rst_mid_ovalid", {31'h0, a_out_valid}, 32'h0);
        chk("rst_mid_odata", {24'h0, a_out_data}, 32'h0);
        chk("rst_mid_ready", {30'h0, a_in_ready}, 32'h0);
        a_sel = 1'b0;
        a_in_valid = 2'b11; a_in_data = {8'h22, 8'h99}; a_in_last = 2'b01;
        @(negedge clk);
        areset_n = 1'b1;
        #1;
        chk("post_rst_ready", {30'h0, a_in_ready}, 32'h1);
        @(posedge clk);
        #1;
        a_in_valid = 2'b00;
        @(negedge clk);
        chk("post_rst_ovalid", {31'h0, a_out_valid}, 32'h1);
        chk("post_rst_odata", {24'h0, a_out_data}, 32'h99);
        chk("post_rst_olast", {31'h0, a_out_last}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pkt_mux_reg
`default_nettype wire

// File: doc/pkt_mux_reg.md
PKT_MUX_REG -- requirements
Module: pkt_mux_reg

Interface
REQ-001 SHALL have parameter W, default 8, meaning data width in bits (W >= 1).
REQ-002 SHALL have parameter N, default 2, meaning input channel count (2 <= N <= 16); SW = max(1, clog2(N)).
REQ-003 SHALL have parameter MODE, default MODE_SEL, meaning grant policy (MODE_SEL = explicit select, MODE_RR = round-robin).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 areset_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  N  per-channel beat valid.
REQ-007 in_data  input  N*W  channel i occupies bits [i*W +: W].
REQ-008 in_last  input  N  per-channel last beat of packet.
REQ-009 in_ready  output  N  per-channel accept; at most one bit high per cycle.
REQ-010 sel_en  input  1  MODE_SEL only: 1 = use sel, 0 = default to channel 0.
REQ-011 sel  input  SW  MODE_SEL only: requested channel index.
REQ-012 out_valid  output  1  registered output beat valid.
REQ-013 out_data  output  W  registered output data.
REQ-014 out_last  output  1  registered output last.
REQ-015 out_ready  input  1  downstream accept.

Function
REQ-016 A beat SHALL transfer on an input when in_valid[i] & in_ready[i] at a rising edge, and on the output when out_valid & out_ready.
REQ-017 The output stage SHALL be one register; load_ok = !out_valid | out_ready; in_ready[g] = load_ok & granted & (locked | candidate valid), combinationally.
REQ-018 Latency SHALL be exactly 1 cycle from input transfer to out_valid high with that beat's data/last.
REQ-019 Simultaneous output drain and input load in one cycle SHALL sustain one beat per cycle with no bubble.
REQ-020 State machine SHALL have states IDLE (no grant held) and LOCK (grant held mid-packet).
REQ-021 IDLE -> LOCK on transfer of a beat with in_last = 0; channel latched as grant.
REQ-022 In IDLE, transfer of a beat with in_last = 1 (single-beat packet) SHALL stay in IDLE.
REQ-023 LOCK -> IDLE on transfer of the granted channel's beat with in_last = 1.
REQ-024 In LOCK the granted channel SHALL be held regardless of sel, sel_en or other channels' valid; grant never changes mid-packet.
REQ-025 MODE_SEL, IDLE: candidate = sel_en ? sel : 0; if sel >= N no channel SHALL be ready.
REQ-026 MODE_RR, IDLE: candidate = first valid channel searching upward from rr_ptr, wrapping N-1 -> 0; none valid -> no grant.
REQ-027 MODE_RR: rr_ptr SHALL update to (grant + 1) mod N on transfer of a last beat; reset value 0.
REQ-028 Unselected channels SHALL see in_ready = 0 and their valid/data SHALL not affect outputs.
REQ-029 out_data/out_last SHALL hold stable while out_valid & !out_ready.

Reset
REQ-030 On areset_n low, asynchronously: out_valid = 0, out_data = 0, out_last = 0, state = IDLE, rr_ptr = 0; in_ready = 0 while in reset.
REQ-031 Reset mid-packet SHALL discard the held beat and the lock; first post-reset grant SHALL follow IDLE rules.
REQ-032 Deassertion takes effect at the first rising clk after areset_n goes high; no transfer in that edge's preceding reset period.

Structure
REQ-033 Package mux_pkg SHALL hold MODE_SEL = 0, MODE_RR = 1 and the state enum (IDLE, LOCK).
REQ-034 Round-robin search SHALL be sub-module rr_arbiter (inputs req[N], ptr; output grant index, grant_valid).
REQ-035 Parameter checks (N range, MODE legal) SHALL be elaboration-time assertions.

Verification
REQ-036 MODE_SEL, N=2, W=8: sel_en=0, ch0 sends 0xA5 last=1, ch1 valid -> out 0xA5 one cycle later, in_ready[1]=0 throughout.
REQ-037 MODE_SEL: sel_en=1, sel=1, ch1 3-beat packet 0x11,0x22,0x33; sel flips to 0 after beat 1 -> all three beats out in order, ch0 not ready until after 0x33.
REQ-038 Backpressure: out_ready=0 for 4 cycles with out_valid=1, data 0x5A -> out_data stays 0x5A, in_ready all 0; out_ready=1 -> one beat per cycle resumes.
REQ-039 MODE_RR, N=4: all channels continuously valid, single-beat packets -> grant order 0,1,2,3,0 on consecutive cycles.
REQ-040 MODE_SEL, N=3: sel=3 -> in_ready=0, out_valid stays 0.
REQ-041 areset_n pulsed low mid 3-beat packet -> out_valid=0 immediately; after release new sel honoured on first beat.
